// File: rtl/modexp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// modexp_ctrl: left-to-right square-and-multiply M^E mod N over one monpro.
// Option MODEXP_SKIP_LEADING_ZEROS_EN: scan past leading zeros of E first.
// Revision: 1.0
// =============================================================================
module modexp_ctrl #(
  parameter int DATAWIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATAWIDTH-1:0] i_M,
  input  logic [DATAWIDTH-1:0] i_E,
  input  logic [DATAWIDTH-1:0] i_N,
  input  logic [DATAWIDTH-1:0] i_R_MOD_N,
  input  logic [DATAWIDTH-1:0] i_R2_MOD_N,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATAWIDTH-1:0] o_C,
  output logic                 mp_start,
  input  logic                 mp_ready,
  input  logic                 mp_valid,
  output logic [DATAWIDTH-1:0] mp_A,
  output logic [DATAWIDTH-1:0] mp_B,
  output logic [DATAWIDTH-1:0] mp_N,
  input  logic [DATAWIDTH-1:0] mp_U
);

  localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);
  localparam logic [IW-1:0] TOP_BIT = IW'(DATAWIDTH - 1);

  typedef enum logic [3:0] {
    IDLE, MBAR_ISSUE, MBAR_WAIT, SQ_ISSUE, SQ_WAIT,
    MUL_ISSUE, MUL_WAIT, POST_ISSUE, POST_WAIT, DONE
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    , SCAN
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [DATAWIDTH-1:0]   e_reg, n_reg, x_reg, mbar_reg, a_reg, b_reg, c_reg;
  logic [IW-1:0]          idx;
  logic                   bit_set, last_bit;
  logic                   load_sq, load_mul, load_post, dec_idx;
  logic [DATAWIDTH-1:0]   x_src;

  assign bit_set  = e_reg[idx];
  assign last_bit = (idx == '0);

  assign mp_A = a_reg;
  assign mp_B = b_reg;
  assign mp_N = n_reg;
  assign o_C  = c_reg;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs are masked by rstn so they read 0 while reset is held.
  always_comb begin
    state_nxt = state;
    mp_start  = 1'b0;
    o_ready   = rstn && (state == IDLE);
    o_valid   = rstn && (state == DONE);
    load_sq   = 1'b0;
    load_mul  = 1'b0;
    load_post = 1'b0;
    dec_idx   = 1'b0;
    x_src     = mp_U;
    case (state)
      IDLE:       if (i_valid) state_nxt = MBAR_ISSUE;
      MBAR_ISSUE: if (mp_ready) begin mp_start = rstn; state_nxt = MBAR_WAIT; end
      SQ_ISSUE:   if (mp_ready) begin mp_start = rstn; state_nxt = SQ_WAIT;   end
      MUL_ISSUE:  if (mp_ready) begin mp_start = rstn; state_nxt = MUL_WAIT;  end
      POST_ISSUE: if (mp_ready) begin mp_start = rstn; state_nxt = POST_WAIT; end
      MBAR_WAIT: begin
        x_src = x_reg;
        if (mp_valid) begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          state_nxt = SCAN;
`else
          load_sq   = 1'b1;
          state_nxt = SQ_ISSUE;
`endif
        end
      end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      SCAN: begin
        x_src = x_reg;
        if (bit_set) begin
          load_sq   = 1'b1;
          state_nxt = SQ_ISSUE;
        end else if (last_bit) begin
          load_post = 1'b1;
          state_nxt = POST_ISSUE;
        end else begin
          dec_idx = 1'b1;
        end
      end
`endif
      SQ_WAIT: if (mp_valid) begin
        if (bit_set) begin
          load_mul  = 1'b1;
          state_nxt = MUL_ISSUE;
        end else if (last_bit) begin
          load_post = 1'b1;
          state_nxt = POST_ISSUE;
        end else begin
          dec_idx   = 1'b1;
          load_sq   = 1'b1;
          state_nxt = SQ_ISSUE;
        end
      end
      MUL_WAIT: if (mp_valid) begin
        if (last_bit) begin
          load_post = 1'b1;
          state_nxt = POST_ISSUE;
        end else begin
          dec_idx   = 1'b1;
          load_sq   = 1'b1;
          state_nxt = SQ_ISSUE;
        end
      end
      POST_WAIT: if (mp_valid) state_nxt = DONE;
      DONE:      if (i_ready)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Operands for the next op are loaded as the previous result lands, so
  // mp_A/mp_B are already stable when the ISSUE state is entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_reg    <= '0;
      n_reg    <= '0;
      x_reg    <= '0;
      mbar_reg <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      idx      <= '0;
    end else begin
      if (state == IDLE && i_valid) begin
        e_reg <= i_E;
        n_reg <= i_N;
        x_reg <= i_R_MOD_N;
        idx   <= TOP_BIT;
        a_reg <= i_M;
        b_reg <= i_R2_MOD_N;
      end
      if (state == MBAR_WAIT && mp_valid) mbar_reg <= mp_U;
      if ((state == SQ_WAIT || state == MUL_WAIT) && mp_valid) x_reg <= mp_U;
      if (state == POST_WAIT && mp_valid) c_reg <= mp_U;
      if (dec_idx) idx <= idx - IW'(1);
      if (load_sq) begin
        a_reg <= x_src;
        b_reg <= x_src;
      end
      if (load_mul) begin
        a_reg <= x_src;
        b_reg <= mbar_reg;
      end
      if (load_post) begin
        a_reg <= x_src;
        b_reg <= ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_modexp_ctrl: table + random checks of modexp_ctrl against plain modpow,
// with a 5-cycle behavioural monpro. Revision: 1.0
// =============================================================================
module tb_modexp_ctrl;

  localparam int W   = 8;
  localparam int NM  = 8'h8F;
  localparam int RM  = 8'h71;
  localparam int R2  = 8'h2A;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_valid = 1'b0, o_ready, o_valid, i_ready = 1'b0;
  logic [W-1:0] i_M = '0, i_E = '0, i_N = '0, i_R_MOD_N = '0, i_R2_MOD_N = '0, o_C;
  logic         mp_start, mp_ready;
  logic         mp_valid = 1'b0;
  logic [W-1:0] mp_A, mp_B, mp_N;
  logic [W-1:0] mp_U = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  modexp_ctrl #(.DATAWIDTH(W)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_M(i_M), .i_E(i_E), .i_N(i_N), .i_R_MOD_N(i_R_MOD_N), .i_R2_MOD_N(i_R2_MOD_N),
    .o_valid(o_valid), .i_ready(i_ready), .o_C(o_C),
    .mp_start(mp_start), .mp_ready(mp_ready), .mp_valid(mp_valid),
    .mp_A(mp_A), .mp_B(mp_B), .mp_N(mp_N), .mp_U(mp_U)
  );

  // ---------------- behavioural monpro ----------------
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    int rinv = 0;
    for (int r = 1; r < NM; r++) if (((256 * r) % NM) == 1) rinv = r;
    return W'((int'(a) * int'(b) % NM) * rinv % NM);
  endfunction

  logic         busy = 1'b0, owned = 1'b0;
  logic         stall_en = 1'b0, spur_en = 1'b0;
  int           cnt = 0, idle_cnt = 3, starts = 0, hs_err = 0, stab_err = 0;
  logic [W-1:0] a_cap = '0, b_cap = '0;

  assign mp_ready = !busy && (!stall_en || idle_cnt >= 3);

  always @(posedge clk) begin
    if (mp_start) begin
      if (!mp_ready) hs_err <= hs_err + 1;
      busy     <= 1'b1;
      owned    <= 1'b1;
      cnt      <= LAT - 1;
      a_cap    <= mp_A;
      b_cap    <= mp_B;
      mp_valid <= 1'b0;
      starts   <= starts + 1;
    end else if (busy) begin
      if (owned && rstn && (mp_A !== a_cap || mp_B !== b_cap)) stab_err <= stab_err + 1;
      if (cnt == 0) begin
        busy     <= 1'b0;
        mp_valid <= 1'b1;
        mp_U     <= mont(a_cap, b_cap);
        idle_cnt <= 0;
      end else begin
        cnt      <= cnt - 1;
        mp_valid <= 1'b0;
      end
    end else begin
      mp_valid <= spur_en && !mp_ready;
      if (spur_en && !mp_ready) mp_U <= W'($urandom);
      if (idle_cnt < 3) idle_cnt <= idle_cnt + 1;
    end
    if (i_valid && o_ready) idle_cnt <= 0;
    if (!rstn) owned <= 1'b0;
  end

  // ---------------- reference ----------------
  function automatic int ref_pow(input int m, input int e);
    int c = 1;
    for (int k = 0; k < e; k++) c = (c * m) % NM;
    return c;
  endfunction

  function automatic int exp_ops(input logic [W-1:0] e);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    int h = -1;
    for (int k = 0; k < W; k++) if (e[k]) h = k;
    return 1 + (h + 1) + $countones(e) + 1;
`else
    return 1 + W + $countones(e) + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] e,
                        input logic [W-1:0] exp_c, input int hold);
    int cyc, base, bad_v, bad_c, bad_r;
    logic [W-1:0] saved;
    cyc = 0;
    while (!o_ready && cyc < 200) begin @(negedge clk); cyc++; end
    check("o_ready_idle", o_ready, 1);
    i_M = m; i_E = e; i_N = W'(NM); i_R_MOD_N = W'(RM); i_R2_MOD_N = W'(R2);
    i_valid = 1'b1;
    base = starts;
    @(negedge clk);
    i_valid = 1'b0;
    check("o_ready_busy", o_ready, 0);
    check("mp_N", mp_N, NM);
    cyc = 0;
    while (!o_valid && cyc < 5000) begin @(negedge clk); cyc++; end
    check("o_valid_seen", o_valid, 1);
    check("o_C", o_C, exp_c);
    check("op_count", starts - base, exp_ops(e));
    saved = o_C;
    bad_v = 0; bad_c = 0; bad_r = 0;
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'b1;
      i_M = W'($urandom);
      @(negedge clk);
      if (o_valid !== 1'b1) bad_v++;
      if (o_C !== saved)    bad_c++;
      if (o_ready !== 1'b0) bad_r++;
    end
    if (hold > 0) begin
      check("hold_o_valid", bad_v, 0);
      check("hold_o_C", bad_c, 0);
      check("hold_o_ready", bad_r, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("post_hs_o_valid", o_valid, 0);
    check("post_hs_o_ready", o_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] e;
    logic [W-1:0] c;
    int           hold;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc, base;
    logic [W-1:0] rm, re;
    vecs[0] = '{m: 8'h05, e: 8'h03, c: 8'h7D, hold: 0};
    vecs[1] = '{m: 8'h05, e: 8'h00, c: 8'h01, hold: 0};
    vecs[2] = '{m: 8'h05, e: 8'h01, c: 8'h05, hold: 0};
    vecs[3] = '{m: 8'h00, e: 8'h07, c: 8'h00, hold: 0};
    vecs[4] = '{m: 8'h05, e: 8'h03, c: 8'h7D, hold: 10};

    // reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o_ready", o_ready, 0);
    check("rst_mp_start", mp_start, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_o_ready", o_ready, 1);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_C", o_C, 0);
    check("reset_mp_AB", {mp_A, mp_B, mp_N}, 0);

    for (int v = 0; v < 5; v++) run_op(vecs[v].m, vecs[v].e, vecs[v].c, vecs[v].hold);

    // monpro stalls 3 cycles before each op and fires stray mp_valid meanwhile
    stall_en = 1'b1;
    spur_en  = 1'b1;
    run_op(8'h05, 8'h03, 8'h7D, 0);
    stall_en = 1'b0;
    spur_en  = 1'b0;
    check("start_only_when_ready", hs_err, 0);
    check("operands_stable", stab_err, 0);

    for (int k = 0; k < 8; k++) begin
      rm = W'($urandom_range(0, NM - 1));
      re = W'($urandom_range(0, 255));
      run_op(rm, re, W'(ref_pow(int'(rm), int'(re))), 0);
    end

    // reset while the first squaring is in flight
    i_M = 8'h05; i_E = 8'hFF; i_N = W'(NM); i_R_MOD_N = W'(RM); i_R2_MOD_N = W'(R2);
    i_valid = 1'b1;
    base = starts;
    @(negedge clk);
    i_valid = 1'b0;
    cyc = 0;
    while (starts < base + 2 && cyc < 200) begin @(negedge clk); cyc++; end
    check("reached_sq", starts - base, 2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("midrst_o_ready", o_ready, 1);
    check("midrst_o_valid", o_valid, 0);
    check("midrst_mp_start", mp_start, 0);
    check("midrst_o_C", o_C, 0);
    run_op(8'h02, 8'h05, 8'h20, 0);

    check("final_hs_err", hs_err, 0);
    check("final_stab_err", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
Modular-exponentiation controller that drives a monpro instance through its start/ready/o_valid interface. It computes C = M^E mod N using left-to-right binary square-and-multiply in the Montgomery domain. It sits between the RSA core's operand/result stream and a single monpro datapath. It owns all sequencing and issues every monpro operation; monpro performs the arithmetic.

Parameters:
DATAWIDTH, 256, operand/modulus/exponent width in bits; monpro must be built with the same value.

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
i_valid  input  1  operand set valid
o_ready  output  1  controller can accept operands (high only in IDLE)
i_M  input  DATAWIDTH  message, M < N
i_E  input  DATAWIDTH  exponent
i_N  input  DATAWIDTH  modulus, odd
i_R_MOD_N  input  DATAWIDTH  R mod N, R = 2^DATAWIDTH
i_R2_MOD_N  input  DATAWIDTH  R^2 mod N
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_C  output  DATAWIDTH  result M^E mod N
mp_start  output  1  monpro start pulse
mp_ready  input  1  monpro idle
mp_valid  input  1  monpro result pulse
mp_A  output  DATAWIDTH  monpro operand A
mp_B  output  DATAWIDTH  monpro operand B
mp_N  output  DATAWIDTH  monpro modulus
mp_U  input  DATAWIDTH  monpro result

Behaviour:
- One clock. Reset is synchronous and active-low on rstn. All state registers update only on the rising edge of clk.
- Reset values: o_ready=0 during reset and 1 in the first cycle after; o_valid=0; mp_start=0; o_C, mp_A, mp_B, mp_N, internal registers all 0; state=IDLE.
- Input handshake: a transfer occurs when i_valid && o_ready. On transfer, latch M, E, N, R_MOD_N and R2_MOD_N. Set X=R_MOD_N and bit index i=DATAWIDTH-1.
- mp_N is driven from latched N for the whole operation.
- Monpro handshake, used for every operation:
  - ISSUE state: drive mp_A/mp_B, then assert mp_start for exactly one cycle, only in a cycle where mp_ready=1. If mp_ready=0, wait with mp_start=0.
  - WAIT state: hold mp_A/mp_B stable. On the cycle mp_valid=1, capture mp_U.
- FSM states: IDLE, MBAR_ISSUE, MBAR_WAIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, POST_ISSUE, POST_WAIT, DONE.
- Transitions:
  - IDLE -> MBAR_ISSUE on input transfer.
  - MBAR: monpro(M, R2_MOD_N) -> Mbar. Then -> SQ_ISSUE.
  - SQ: monpro(X, X) -> X. Then -> MUL_ISSUE if E[i]=1. Otherwise, if i==0 -> POST_ISSUE; else i-=1 and -> SQ_ISSUE.
  - MUL: monpro(X, Mbar) -> X. Then, if i==0 -> POST_ISSUE; else i-=1 and -> SQ_ISSUE.
  - POST: monpro(X, 1), where 1 is zero-extended to DATAWIDTH -> o_C. Then -> DONE.
  - DONE: o_valid=1, o_C held stable until i_ready=1. That handshake cycle -> IDLE with o_valid=0 and o_ready=1 in the next cycle.
- Bit index width is $clog2(DATAWIDTH), unsigned. Decrement never wraps, because i==0 exits the loop.
- Op count without the optional feature: 1 + DATAWIDTH + popcount(E) + 1.
- Boundary conditions:
  - E=0 produces C=1.
  - M=0 produces C=0 for E>0.
  - mp_valid outside a WAIT state is ignored.
  - i_valid outside IDLE is ignored; o_ready=0.
  - Reset mid-operation returns to IDLE with reset values. A late mp_valid after reset is ignored.
- Back-to-back operation: a new operand set may be accepted in the cycle after the DONE handshake.

Optional Feature:
Macro: MODEXP_SKIP_LEADING_ZEROS_EN.
- Defined: after latching, SQ/MUL are skipped for every bit above the most significant 1 of E. Squaring R mod N in Montgomery form is the identity, so the result is unchanged.
  - The leading-zero scan advances one bit per cycle in a SCAN state between MBAR_WAIT and SQ_ISSUE.
  - E=0 goes SCAN -> POST_ISSUE directly.
  - Op count: 1 + (msb(E)+1) + popcount(E) + 1.
- Undefined: no SCAN state; all DATAWIDTH bits are processed.
- o_C is identical in both builds.

Test Plan:
- Bench setup: DATAWIDTH=8, behavioural monpro model with 5-cycle latency. N=0x8F, R_MOD_N=0x71, R2_MOD_N=0x2A.
- M=0x05, E=0x03 -> o_C=0x7D. mp_start count = 12 (undefined) or 6 (defined).
- M=0x05, E=0x00 -> o_C=0x01. M=0x05, E=0x01 -> o_C=0x05. M=0x00, E=0x07 -> o_C=0x00.
- Hold i_ready=0 for 10 cycles after o_valid -> o_valid stays 1 and o_C stays stable. o_ready=0 throughout; i_valid during this time is ignored.
- Model holds mp_ready=0 for 3 cycles before each op -> mp_start is asserted only when mp_ready=1, exactly one pulse per op, and mp_A/mp_B are stable until mp_valid. Result is unchanged.
- Drive rstn=0 for 1 cycle mid-SQ_WAIT -> next cycle o_ready=1, o_valid=0, mp_start=0. A new M=0x02, E=0x05 -> o_C=0x20.
